// File: rtl/prod_accum.sv
// Streaming dot-product accumulator: sums len_i unsigned products, then holds the result until consumed.
// Define PROD_ACCUM_SAT_EN to saturate on overflow (with sticky ovf_o); otherwise the sum wraps modulo 2^ACC_W.
module prod_accum #(
  parameter int ACC_W = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       prod_i,
  input  logic             prod_valid_i,
  output logic             prod_ready_o,
  input  logic [3:0]       len_i,
  input  logic             clear_i,
  output logic [ACC_W-1:0] acc_o,
  output logic             acc_valid_o,
  input  logic             acc_ready_i,
  output logic             busy_o,
  output logic             ovf_o
);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [4:0]       cnt_q, cnt_d;
  logic [4:0]       len_q, len_d;
  logic             ovf_q, ovf_d;
  logic             ready_q;
  logic [ACC_W:0]   sum;
  logic             take;

  // Returns {overflow, value}; overflow can only be flagged in saturating builds.
  function automatic logic [ACC_W:0] add_sat(input logic [ACC_W-1:0] a, input logic [7:0] b);
    logic [ACC_W:0] s;
    s = {1'b0, a} + (ACC_W+1)'(b);
`ifdef PROD_ACCUM_SAT_EN
    return s[ACC_W] ? {1'b1, {ACC_W{1'b1}}} : s;
`else
    return {1'b0, s[ACC_W-1:0]};
`endif
  endfunction

  assign take = prod_valid_i & ready_q;
  assign sum  = add_sat(acc_q, prod_i);

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    ovf_d   = ovf_q;
    if (clear_i) begin
      state_d = IDLE;
      acc_d   = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (take) begin
            acc_d   = ACC_W'(prod_i);
            cnt_d   = 5'd1;
            len_d   = (len_i == 4'd0) ? 5'd16 : {1'b0, len_i};
            ovf_d   = 1'b0;
            state_d = (len_d == 5'd1) ? DONE : ACCUM;
          end
        end
        ACCUM: begin
          if (take) begin
            acc_d = sum[ACC_W-1:0];
            ovf_d = ovf_q | sum[ACC_W];
            cnt_d = cnt_q + 5'd1;
            if (cnt_d == len_q) state_d = DONE;
          end
        end
        DONE: begin
          if (acc_ready_i) begin
            state_d = IDLE;
            ovf_d   = 1'b0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Ready is registered from the next state so it drops on the edge that enters DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      ovf_q   <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      ovf_q   <= ovf_d;
      ready_q <= (state_d != DONE);
    end
  end

  assign prod_ready_o = ready_q;
  assign acc_o        = acc_q;
  assign acc_valid_o  = (state_q == DONE);
  assign busy_o       = (state_q != IDLE);
  assign ovf_o        = ovf_q;

endmodule

// File: tb/tb_prod_accum.sv
// Scoreboard bench for prod_accum: a 12-bit instance for the main scenarios, a 10-bit one for overflow.
module tb_prod_accum;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  prod_i = 8'd0;
  logic        v12 = 1'b0, v10 = 1'b0;
  logic [3:0]  len_i = 4'd0;
  logic        clear_i = 1'b0;
  logic        acc_ready_i = 1'b0;

  logic        r12, av12, b12, o12;
  logic [11:0] acc12;
  logic        r10, av10, b10, o10;
  logic [9:0]  acc10;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int acc;
    bit ovf;
  } exp_t;
  exp_t q12[$];
  exp_t q10[$];

`ifdef PROD_ACCUM_SAT_EN
  localparam int EXP10_ACC = 1023;
  localparam int EXP10_OVF = 1;
`else
  localparam int EXP10_ACC = 776;
  localparam int EXP10_OVF = 0;
`endif

  prod_accum #(.ACC_W(12)) u_dut12 (
    .clk(clk), .rst_n(rst_n), .prod_i(prod_i), .prod_valid_i(v12), .prod_ready_o(r12),
    .len_i(len_i), .clear_i(clear_i), .acc_o(acc12), .acc_valid_o(av12),
    .acc_ready_i(acc_ready_i), .busy_o(b12), .ovf_o(o12)
  );

  prod_accum #(.ACC_W(10)) u_dut10 (
    .clk(clk), .rst_n(rst_n), .prod_i(prod_i), .prod_valid_i(v10), .prod_ready_o(r10),
    .len_i(len_i), .clear_i(clear_i), .acc_o(acc10), .acc_valid_o(av10),
    .acc_ready_i(acc_ready_i), .busy_o(b10), .ovf_o(o10)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push12(input int a, input bit o);
    exp_t e;
    e.acc = a;
    e.ovf = o;
    q12.push_back(e);
  endtask

  task automatic push10(input int a, input bit o);
    exp_t e;
    e.acc = a;
    e.ovf = o;
    q10.push_back(e);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Presents one product and holds it until the chosen instance accepts it.
  task automatic send(input bit d10, input logic [7:0] p);
    int n;
    n = 0;
    prod_i = p;
    if (d10) v10 = 1'b1;
    else     v12 = 1'b1;
    forever begin
      @(negedge clk);
      if ((d10 ? r10 : r12) === 1'b1) break;
      n++;
      if (n > 200) begin
        checks++;
        errors++;
        $display("FAIL send_timeout: got ready=0 for 200 cycles expected ready=1");
        break;
      end
    end
    @(posedge clk);
    #1;
    v10 = 1'b0;
    v12 = 1'b0;
  endtask

  // Result monitors: compare at every result transfer.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && av12 === 1'b1 && acc_ready_i) begin
      if (q12.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result12: got acc=%0d expected no result", acc12);
      end else begin
        e = q12.pop_front();
        chk("result12_acc", int'(acc12), e.acc);
        chk("result12_ovf", int'(o12), int'(e.ovf));
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && av10 === 1'b1 && acc_ready_i) begin
      if (q10.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result10: got acc=%0d expected no result", acc10);
      end else begin
        e = q10.pop_front();
        chk("result10_acc", int'(acc10), e.acc);
        chk("result10_ovf", int'(o10), int'(e.ovf));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    cyc(3);
    chk("rst_acc", int'(acc12), 0);
    chk("rst_valid", int'(av12), 0);
    chk("rst_busy", int'(b12), 0);
    chk("rst_ready", int'(r12), 0);
    chk("rst_ovf", int'(o12), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("ready_before_edge", int'(r12), 0);
    @(posedge clk);
    #1;
    chk("ready_after_reset", int'(r12), 1);

    // Four back-to-back terms, result held
    len_i = 4'd4;
    acc_ready_i = 1'b0;
    push12(315, 1'b0);
    send(0, 8'd15);
    send(0, 8'd30);
    send(0, 8'd45);
    send(0, 8'd225);
    chk("done_valid", int'(av12), 1);
    chk("done_ready", int'(r12), 0);
    chk("done_busy", int'(b12), 1);
    chk("done_acc", int'(acc12), 315);

    // Products offered while holding must not be counted
    prod_i = 8'd99;
    v12 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      chk("hold_acc", int'(acc12), 315);
      chk("hold_ready", int'(r12), 0);
    end
    acc_ready_i = 1'b1;
    cyc(1);
    v12 = 1'b0;
    acc_ready_i = 1'b0;
    chk("post_xfer_valid", int'(av12), 0);
    chk("post_xfer_ready", int'(r12), 1);
    chk("post_xfer_busy", int'(b12), 0);

    // Single-term dot product goes straight to DONE
    len_i = 4'd1;
    acc_ready_i = 1'b1;
    push12(200, 1'b0);
    send(0, 8'd200);
    chk("len1_valid", int'(av12), 1);
    cyc(2);

    // len 0 means sixteen terms
    len_i = 4'd0;
    push12(3600, 1'b0);
    for (int i = 0; i < 16; i++) send(0, 8'd225);
    cyc(2);

    // Clear after two terms, coincident with a third product
    acc_ready_i = 1'b0;
    len_i = 4'd4;
    send(0, 8'd10);
    send(0, 8'd10);
    prod_i = 8'd50;
    v12 = 1'b1;
    clear_i = 1'b1;
    cyc(1);
    clear_i = 1'b0;
    v12 = 1'b0;
    chk("clr_busy", int'(b12), 0);
    chk("clr_acc", int'(acc12), 0);
    chk("clr_ready", int'(r12), 1);
    chk("clr_valid", int'(av12), 0);

    // Length change after first term is ignored
    len_i = 4'd2;
    acc_ready_i = 1'b1;
    push12(30, 1'b0);
    send(0, 8'd10);
    len_i = 4'd9;
    send(0, 8'd20);
    cyc(2);

    // Gapped valid
    len_i = 4'd3;
    push12(6, 1'b0);
    for (int k = 1; k <= 3; k++) begin
      send(0, 8'(k));
      cyc(int'($urandom_range(0, 3)));
    end
    cyc(2);

    // Asynchronous reset in the middle of accumulation
    acc_ready_i = 1'b0;
    len_i = 4'd5;
    send(0, 8'd7);
    send(0, 8'd8);
    chk("mid_busy", int'(b12), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_acc", int'(acc12), 0);
    chk("arst_busy", int'(b12), 0);
    chk("arst_ready", int'(r12), 0);
    chk("arst_valid", int'(av12), 0);
    chk("arst_ovf", int'(o12), 0);
    cyc(2);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(2);

    // Overflow on the 10-bit instance
    len_i = 4'd8;
    acc_ready_i = 1'b0;
    push10(EXP10_ACC, EXP10_OVF[0]);
    for (int i = 0; i < 8; i++) send(1, 8'd225);
    chk("ovf10_valid", int'(av10), 1);
    cyc(3);
    chk("ovf10_sticky", int'(o10), EXP10_OVF);
    chk("ovf10_held_acc", int'(acc10), EXP10_ACC);
    acc_ready_i = 1'b1;
    cyc(1);
    acc_ready_i = 1'b0;
    chk("ovf10_cleared", int'(o10), 0);
    chk("ovf10_valid_drop", int'(av10), 0);

    cyc(2);
    chk("sb12_empty", q12.size(), 0);
    chk("sb10_empty", q10.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
